data_matrix_ctrl: RTL

DATA_MATRIX_CTRL -- requirements
Module: data_matrix_ctrl

---
 rtl/data_matrix_pkg.sv | 31 +++
 rtl/data_matrix_ctrl_chk.sv | 24 ++
 rtl/data_matrix_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/data_matrix_pkg.sv
// Shared definitions for the data matrix controller.
// Contents:
//   DEF_*      default parameter values of data_matrix_ctrl
//   state_e    controller FSM state encoding
//   min1_clog2 width helper: ceil(log2(value)), never less than 1
package data_matrix_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ROW_WIDTH    = 5;
  localparam int DEF_KERNEL_WIDTH = 3;
  localparam int DEF_COL_HEIGHT   = 3;
  localparam int DEF_IMG_HEIGHT   = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_NEXT_ROW = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Width of a counter holding 0..value-1; a zero-bit vector is not legal.
  function automatic int min1_clog2(input int value);
    if (value > 1) begin
      return $clog2(value);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/data_matrix_ctrl_chk.sv
// Property checker for data_matrix_ctrl strobes.
// Ports (all inputs): clk, arst_n, processing, parallel_load_en, shifting_enable.
// Properties:
//   - the load strobe and the shift strobe are never high together
//   - a strobe is only ever high while a frame is in progress
module data_matrix_ctrl_chk (
  input logic clk,
  input logic arst_n,
  input logic processing,
  input logic parallel_load_en,
  input logic shifting_enable
);

  a_strobe_exclusive: assert property (
    @(posedge clk) disable iff (!arst_n)
    !(parallel_load_en && shifting_enable)
  ) else $error("load and shift strobes high together");

  a_strobe_in_frame: assert property (
    @(posedge clk) disable iff (!arst_n)
    (parallel_load_en || shifting_enable) |-> processing
  ) else $error("strobe high outside a frame");

endmodule

// File: rtl/data_matrix_ctrl.sv
// Sliding-window matrix controller.
// Walks a KERNEL_WIDTH x COL_HEIGHT window over a ROW_WIDTH x IMG_HEIGHT image:
// each window row starts with a parallel column load from the line buffers,
// followed by ROW_WIDTH-KERNEL_WIDTH single-pixel shifts taken from the
// upstream valid/ready stream.
// Ports:
//   clk, arst_n                  clock, asynchronous active-low reset
//   start, abort                 frame start request, synchronous frame cancel
//   lb_ready                     line buffers can supply a parallel load
//   pix_valid, pix_data, pix_ready  upstream pixel handshake
//   processing                   frame in progress
//   parallel_load_en             matrix column load strobe
//   shifting_enable, shifting_data  matrix shift strobe and pixel shifted in
//   window_valid, win_row, win_col  complete new window and its position
//   done                         one-cycle end-of-frame pulse
module data_matrix_ctrl
  import data_matrix_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ROW_WIDTH    = DEF_ROW_WIDTH,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int COL_HEIGHT   = DEF_COL_HEIGHT,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  lb_ready,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  processing,
  output logic                  parallel_load_en,
  output logic                  shifting_enable,
  output logic [DATA_WIDTH-1:0] shifting_data,
  output logic                  window_valid,
  output logic [min1_clog2(IMG_HEIGHT-COL_HEIGHT+1)-1:0] win_row,
  output logic [min1_clog2(ROW_WIDTH-KERNEL_WIDTH+1)-1:0] win_col,
  output logic                  done
);

  localparam int ROW_W  = min1_clog2(IMG_HEIGHT - COL_HEIGHT + 1);
  localparam int COL_W  = min1_clog2(ROW_WIDTH - KERNEL_WIDTH + 1);
  localparam int SHIFTS = ROW_WIDTH - KERNEL_WIDTH;
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_HEIGHT - COL_HEIGHT);
  localparam logic [COL_W-1:0] LAST_SHIFT = COL_W'(SHIFTS - 1);

  if (ROW_WIDTH < KERNEL_WIDTH || IMG_HEIGHT < COL_HEIGHT) begin : g_param_check
    $error("data_matrix_ctrl: window does not fit inside the image");
  end

  state_e                state_q, state_d;
  logic                  processing_q, processing_d;
  logic                  load_q, load_d;
  logic                  shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wvalid_q, wvalid_d;
  logic [ROW_W-1:0]      win_row_q, win_row_d;
  logic [COL_W-1:0]      win_col_q, win_col_d;
  logic [COL_W-1:0]      shift_cnt_q, shift_cnt_d;
  logic                  done_q, done_d;

  // Next-state and strobe generation; abort acts as a synchronous clear.
  always_comb begin
    state_d      = state_q;
    processing_d = processing_q;
    load_d       = 1'b0;
    shift_d      = 1'b0;
    data_d       = data_q;
    wvalid_d     = load_q | shift_q;
    win_row_d    = win_row_q;
    shift_cnt_d  = shift_cnt_q;
    done_d       = 1'b0;

    // win_col tracks the strobe already on the outputs, so it lines up with
    // window_valid one cycle later.
    if (load_q) begin
      win_col_d = '0;
    end else if (shift_q) begin
      win_col_d = win_col_q + COL_W'(1);
    end else begin
      win_col_d = win_col_q;
    end

    if (abort) begin
      state_d      = ST_IDLE;
      processing_d = 1'b0;
      data_d       = '0;
      wvalid_d     = 1'b0;
      win_row_d    = '0;
      win_col_d    = '0;
      shift_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d      = ST_LOAD;
            processing_d = 1'b1;
            win_row_d    = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (lb_ready) begin
            load_d      = 1'b1;
            shift_cnt_d = '0;
            // A window as wide as the image needs no shifts at all.
            state_d     = (SHIFTS == 0) ? ST_NEXT_ROW : ST_SHIFT;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_SHIFT: begin
          if (pix_valid) begin
            shift_d     = 1'b1;
            data_d      = pix_data;
            shift_cnt_d = shift_cnt_q + COL_W'(1);
            if (shift_cnt_q == LAST_SHIFT) begin
              state_d = ST_NEXT_ROW;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_NEXT_ROW: begin
          if (win_row_q < LAST_ROW) begin
            win_row_d = win_row_q + ROW_W'(1);
            state_d   = ST_LOAD;
          end else begin
            state_d      = ST_DONE;
            processing_d = 1'b0;
            done_d       = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d      = ST_IDLE;
          processing_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      processing_q <= 1'b0;
      load_q       <= 1'b0;
      shift_q      <= 1'b0;
      data_q       <= '0;
      wvalid_q     <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      shift_cnt_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      processing_q <= processing_d;
      load_q       <= load_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      wvalid_q     <= wvalid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      shift_cnt_q  <= shift_cnt_d;
      done_q       <= done_d;
    end
  end

  assign pix_ready        = (state_q == ST_SHIFT);
  assign processing       = processing_q;
  assign parallel_load_en = load_q;
  assign shifting_enable  = shift_q;
  assign shifting_data    = data_q;
  assign window_valid     = wvalid_q;
  assign win_row          = win_row_q;
  assign win_col          = win_col_q;
  assign done             = done_q;

endmodule
